// File: rtl/spi_ram_arb_pkg.sv
// Shared defaults and owner encoding for the two-master RAM arbiter.
package spi_ram_arb_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int DATA_W_DEF   = 32;
    localparam int NUMWORDS_DEF = 10240;

    // Which master owns the read currently in flight (if any).
    typedef enum logic [1:0] {
        OWN_M0   = 2'd0,
        OWN_M1   = 2'd1,
        OWN_NONE = 2'd2
    } owner_e;

endpackage

// File: rtl/spi_ram_rr_arbiter.sv
// Two-way grant logic. The grant is combinational from the live requests and
// the last_grant register; ARB_MODE selects round-robin (0) or m0 priority (1).
module spi_ram_rr_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req0_i,
    input  logic   req1_i,
    output logic   gnt0_o,
    output logic   gnt1_o,
    output owner_e owner_o
);

    // 1 means m1 was granted last; the reset value lets m0 win the first conflict.
    logic last_grant_q;
    logic last_grant_d;

    // Grant decision: a lone requester always wins, a conflict is resolved by mode.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (reset_n) begin
            if (req0_i && req1_i) begin
                if ((ARB_MODE == 1) || last_grant_q) begin
                    gnt0_o = 1'b1;
                end else begin
                    gnt1_o = 1'b1;
                end
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    // Owner encoding and the next last_grant value (held when nobody is granted).
    always_comb begin
        owner_o      = OWN_NONE;
        last_grant_d = last_grant_q;
        if (gnt0_o) begin
            owner_o      = OWN_M0;
            last_grant_d = 1'b0;
        end else if (gnt1_o) begin
            owner_o      = OWN_M1;
            last_grant_d = 1'b1;
        end
    end

    // last_grant register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/spi_platform_designer_ram_arbiter.sv
// Two Avalon-MM style masters sharing one single-port RAM. One access per
// cycle, the winner drives the RAM combinationally, and read data returns one
// cycle later to whichever master issued it. Out-of-range accesses are
// accepted but never reach the RAM; reads of them return zero.
module spi_platform_designer_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUMWORDS = NUMWORDS_DEF,
    parameter int ARB_MODE = 0
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,

    output logic                oor_err
);

    logic   gnt0;
    logic   gnt1;
    logic   any_gnt;
    owner_e gnt_owner;

    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic                sel_oor;

    owner_e pend_owner_q, pend_owner_d;
    logic   pend_oor_q,   pend_oor_d;
    logic   oor_err_q,    oor_err_d;

    logic [DATA_W-1:0] rd_gated;

    spi_ram_rr_arbiter #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req0_i  (m0_read | m0_write),
        .req1_i  (m1_read | m1_write),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1),
        .owner_o (gnt_owner)
    );

    assign any_gnt = gnt0 | gnt1;

    // Route the winning master's request; write wins when read and write are both high.
    always_comb begin
        sel_addr  = m0_address;
        sel_be    = m0_byteenable;
        sel_wdata = m0_writedata;
        sel_write = m0_write;
        if (gnt1) begin
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
            sel_write = m1_write;
        end
    end

    assign sel_oor = (32'(sel_addr) >= NUMWORDS);

    assign ram_address    = sel_addr;
    assign ram_byteenable = sel_be;
    assign ram_writedata  = sel_wdata;
    assign ram_chipselect = any_gnt & ~sel_oor;
    assign ram_write      = any_gnt & ~sel_oor & sel_write;
    assign ram_clken      = reset_n;

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    // Track who owns the read returning next cycle and the sticky range error.
    always_comb begin
        pend_owner_d = OWN_NONE;
        pend_oor_d   = 1'b0;
        if (any_gnt && !sel_write) begin
            pend_owner_d = gnt_owner;
            pend_oor_d   = sel_oor;
        end
        oor_err_d = oor_err_q | (any_gnt & sel_oor);
    end

    // Pending-read and error registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_owner_q <= OWN_NONE;
            pend_oor_q   <= 1'b0;
            oor_err_q    <= 1'b0;
        end else begin
            pend_owner_q <= pend_owner_d;
            pend_oor_q   <= pend_oor_d;
            oor_err_q    <= oor_err_d;
        end
    end

    // The RAM was never selected for an out-of-range read, so its output is stale.
    assign rd_gated = pend_oor_q ? '0 : ram_readdata;

    assign m0_readdatavalid = (pend_owner_q == OWN_M0);
    assign m1_readdatavalid = (pend_owner_q == OWN_M1);
    assign m0_readdata      = m0_readdatavalid ? rd_gated : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_gated : '0;
    assign oor_err          = oor_err_q;

endmodule

// File: tb/tb_spi_platform_designer_ram_arbiter.sv
// Bench for the two-master RAM arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model (shadow memory + grant rule).
module tb_spi_platform_designer_ram_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken, oor_err;
    logic [31:0] ram_writedata, ram_readdata;

    logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_m0_readdatavalid, fp_m1_readdatavalid;
    logic [31:0] fp_m0_readdata, fp_m1_readdata;
    logic [13:0] fp_ram_address;
    logic [3:0]  fp_ram_byteenable;
    logic        fp_ram_chipselect, fp_ram_write, fp_ram_clken, fp_oor_err;
    logic [31:0] fp_ram_writedata, fp_ram_readdata;
    assign fp_ram_readdata = 32'h0;

    spi_platform_designer_ram_arbiter #(.ARB_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_clken(ram_clken), .ram_readdata(ram_readdata), .oor_err(oor_err)
    );

    spi_platform_designer_ram_arbiter #(.ARB_MODE(1)) u_dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fp_m0_waitrequest),
        .m0_readdata(fp_m0_readdata), .m0_readdatavalid(fp_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fp_m1_waitrequest),
        .m1_readdata(fp_m1_readdata), .m1_readdatavalid(fp_m1_readdatavalid),
        .ram_address(fp_ram_address), .ram_byteenable(fp_ram_byteenable),
        .ram_chipselect(fp_ram_chipselect), .ram_write(fp_ram_write),
        .ram_writedata(fp_ram_writedata), .ram_clken(fp_ram_clken),
        .ram_readdata(fp_ram_readdata), .oor_err(fp_oor_err)
    );

    // RAM: registered address, unregistered data out, byte-lane writes.
    logic [31:0] mem [0:16383] = '{default: 32'h0};
    logic [13:0] ram_addr_q = 14'h0;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_addr_q <= ram_address;
        end
    end
    assign ram_readdata = mem[ram_addr_q];

    // Transaction-level reference model.
    localparam int NUMWORDS = 10240;
    logic [31:0] shadow [int];
    int          mdl_last;        // master that won most recently
    int          mdl_pend;        // master expecting data next cycle, -1 if none
    logic [31:0] mdl_pend_data;
    bit          mdl_oor;

    int          exp_g;
    bit          exp_cs, exp_we, exp_rdv0, exp_rdv1, exp_oor;
    logic [31:0] exp_rd0, exp_rd1;
    logic [13:0] exp_addr;

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_reset();
        mdl_last = 1;
        mdl_pend = -1;
        mdl_oor  = 1'b0;
    endtask

    task automatic model_eval();
        bit a0, a1, wr;
        a0 = m0_read | m0_write;
        a1 = m1_read | m1_write;
        if (a0 && a1)  exp_g = (mdl_last == 0) ? 1 : 0;
        else if (a0)   exp_g = 0;
        else if (a1)   exp_g = 1;
        else           exp_g = -1;
        exp_addr = (exp_g == 1) ? m1_address : m0_address;
        wr       = (exp_g == 1) ? m1_write : m0_write;
        exp_cs   = (exp_g >= 0) && (int'(exp_addr) < NUMWORDS);
        exp_we   = exp_cs && wr;
        exp_rdv0 = (mdl_pend == 0);
        exp_rdv1 = (mdl_pend == 1);
        exp_rd0  = exp_rdv0 ? mdl_pend_data : 32'h0;
        exp_rd1  = exp_rdv1 ? mdl_pend_data : 32'h0;
        exp_oor  = mdl_oor;
    endtask

    task automatic model_commit();
        logic [31:0] cur, d;
        logic [3:0]  be;
        bit          wr, inr;
        int          a;
        mdl_pend = -1;
        if (exp_g >= 0) begin
            mdl_last = exp_g;
            a   = int'(exp_addr);
            inr = (a < NUMWORDS);
            wr  = (exp_g == 1) ? m1_write : m0_write;
            be  = (exp_g == 1) ? m1_byteenable : m0_byteenable;
            d   = (exp_g == 1) ? m1_writedata : m0_writedata;
            if (!inr) mdl_oor = 1'b1;
            if (wr) begin
                if (inr) begin
                    cur = shadow.exists(a) ? shadow[a] : 32'h0;
                    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
                    shadow[a] = cur;
                end
            end else begin
                mdl_pend      = exp_g;
                mdl_pend_data = (inr && shadow.exists(a)) ? shadow[a] : 32'h0;
            end
        end
    endtask

    task automatic set_idle();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 14'(10240 + $urandom_range(0, 6000));
        return 14'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        m0_read = 1; m1_write = 1; m1_address = 14'h3;
        model_reset();
        #1;
        n_total++; if (m0_waitrequest !== 1'b1) $display("FAIL rst_wait0 got=%b exp=1", m0_waitrequest); else n_pass++;
        n_total++; if (m1_waitrequest !== 1'b1) $display("FAIL rst_wait1 got=%b exp=1", m1_waitrequest); else n_pass++;
        n_total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL rst_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); else n_pass++;
        n_total++; if ({ram_chipselect, ram_write, ram_clken} !== 3'b000) $display("FAIL rst_ram got=%b exp=000", {ram_chipselect, ram_write, ram_clken}); else n_pass++;
        n_total++; if (oor_err !== 1'b0) $display("FAIL rst_oor got=%b exp=0", oor_err); else n_pass++;
        @(negedge clk);
        set_idle();
        reset_n = 1'b1;
        #1;
        n_total++; if (ram_clken !== 1'b1) $display("FAIL rst_clken_after got=%b exp=1", ram_clken); else n_pass++;
    endtask

    task automatic test_write_read();
        @(negedge clk); set_idle();
        m0_write = 1; m0_address = 14'h10; m0_byteenable = 4'hF; m0_writedata = 32'hA5A5A5A5;
        #1; model_eval();
        n_total++; if (m0_waitrequest !== 1'b0) $display("FAIL wr_wait0 got=%b exp=0", m0_waitrequest); else n_pass++;
        n_total++; if ({ram_chipselect, ram_write} !== 2'b11) $display("FAIL wr_ram got=%b exp=11", {ram_chipselect, ram_write}); else n_pass++;
        n_total++; if (ram_writedata !== 32'hA5A5A5A5) $display("FAIL wr_data got=%h exp=a5a5a5a5", ram_writedata); else n_pass++;
        model_commit();
        @(negedge clk); set_idle();
        m1_read = 1; m1_address = 14'h10;
        #1; model_eval();
        n_total++; if (m1_waitrequest !== 1'b0) $display("FAIL rd_wait1 got=%b exp=0", m1_waitrequest); else n_pass++;
        n_total++; if ({ram_chipselect, ram_write} !== 2'b10) $display("FAIL rd_ram got=%b exp=10", {ram_chipselect, ram_write}); else n_pass++;
        model_commit();
        @(negedge clk); set_idle();
        #1; model_eval();
        n_total++; if (m1_readdatavalid !== 1'b1) $display("FAIL rd_rdv1 got=%b exp=1", m1_readdatavalid); else n_pass++;
        n_total++; if (m1_readdata !== 32'hA5A5A5A5) $display("FAIL rd_data1 got=%h exp=a5a5a5a5", m1_readdata); else n_pass++;
        n_total++; if ({m0_readdatavalid, m0_readdata} !== 33'h0) $display("FAIL rd_nonowner got=%b/%h exp=0/0", m0_readdatavalid, m0_readdata); else n_pass++;
        model_commit();
    endtask

    task automatic test_round_robin();
        int cnt0 = 0, cnt1 = 0;
        bit prev0 = 0, prev1 = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); set_idle();
            if (c < 8) begin
                m0_read = 1; m0_address = 14'h10;
                m1_read = 1; m1_address = 14'h5;
            end
            #1; model_eval();
            if (c < 8) begin
                n_total++; if ({m0_waitrequest, m1_waitrequest} !== ((c % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL rr_grant c=%0d got=%b exp=%b", c, {m0_waitrequest, m1_waitrequest}, (c % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
                n_total++; if ((prev0 && m0_waitrequest) || (prev1 && m1_waitrequest))
                    $display("FAIL rr_consec_wait c=%0d got=%b exp=no repeat", c, {m0_waitrequest, m1_waitrequest});
                else n_pass++;
                prev0 = m0_waitrequest; prev1 = m1_waitrequest;
            end
            n_total++; if (m0_readdata !== exp_rd0 || m1_readdata !== exp_rd1)
                $display("FAIL rr_data c=%0d got=%h/%h exp=%h/%h", c, m0_readdata, m1_readdata, exp_rd0, exp_rd1);
            else n_pass++;
            cnt0 += int'(m0_readdatavalid);
            cnt1 += int'(m1_readdatavalid);
            model_commit();
        end
        n_total++; if (cnt0 != 4 || cnt1 != 4) $display("FAIL rr_rdv_count got=%0d/%0d exp=4/4", cnt0, cnt1); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); set_idle();
            m0_read = 1; m0_address = 14'h7;
            m1_read = 1; m1_address = 14'h8;
            #1; model_eval();
            n_total++; if ({fp_m0_waitrequest, fp_m1_waitrequest} !== 2'b01)
                $display("FAIL fp_grant c=%0d got=%b exp=01", c, {fp_m0_waitrequest, fp_m1_waitrequest});
            else n_pass++;
            model_commit();
        end
    endtask

    task automatic test_byte_enable();
        @(negedge clk); set_idle();
        m0_write = 1; m0_address = 14'h5; m0_byteenable = 4'hF; m0_writedata = 32'hFFFFFFFF;
        #1; model_eval(); model_commit();
        @(negedge clk); set_idle();
        m0_write = 1; m0_address = 14'h5; m0_byteenable = 4'h2; m0_writedata = 32'h11223344;
        #1; model_eval();
        n_total++; if (ram_byteenable !== 4'h2) $display("FAIL be_lanes got=%h exp=2", ram_byteenable); else n_pass++;
        model_commit();
        @(negedge clk); set_idle();
        m0_read = 1; m0_address = 14'h5;
        #1; model_eval(); model_commit();
        @(negedge clk); set_idle();
        #1; model_eval();
        n_total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hFFFF33FF)
            $display("FAIL be_merge got=%b/%h exp=1/ffff33ff", m0_readdatavalid, m0_readdata);
        else n_pass++;
        model_commit();
    endtask

    task automatic test_out_of_range();
        @(negedge clk); set_idle();
        m0_read = 1; m0_address = 14'h10;
        #1; model_eval(); model_commit();
        @(negedge clk); set_idle();
        m1_read = 1; m1_address = 14'd10240;
        #1; model_eval();
        n_total++; if (m1_waitrequest !== 1'b0) $display("FAIL oor_wait1 got=%b exp=0", m1_waitrequest); else n_pass++;
        n_total++; if (ram_chipselect !== 1'b0) $display("FAIL oor_cs got=%b exp=0", ram_chipselect); else n_pass++;
        model_commit();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); set_idle();
            #1; model_eval();
            if (c == 0) begin
                n_total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0)
                    $display("FAIL oor_read got=%b/%h exp=1/00000000", m1_readdatavalid, m1_readdata);
                else n_pass++;
            end
            n_total++; if (oor_err !== 1'b1) $display("FAIL oor_sticky c=%0d got=%b exp=1", c, oor_err); else n_pass++;
            model_commit();
        end
        do_reset();
        #1;
        n_total++; if (oor_err !== 1'b0) $display("FAIL oor_clear got=%b exp=0", oor_err); else n_pass++;
    endtask

    task automatic test_reset_pending();
        @(negedge clk); set_idle();
        m0_read = 1; m0_address = 14'h10;
        #1; model_eval(); model_commit();
        @(negedge clk);
        reset_n = 1'b0;
        set_idle();
        model_reset();
        #1;
        n_total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rstp_in_reset got=%b exp=0", m0_readdatavalid); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); set_idle();
        #1; model_eval();
        n_total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL rstp_after got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); else n_pass++;
        model_commit();
        @(negedge clk); set_idle();
        m0_read = 1; m0_address = 14'h1;
        m1_read = 1; m1_address = 14'h2;
        #1; model_eval();
        n_total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) $display("FAIL rstp_first_win got=%b exp=01", {m0_waitrequest, m1_waitrequest}); else n_pass++;
        model_commit();
    endtask

    task automatic test_random();
        bit hold0 = 0, hold1 = 0;
        int k;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!hold0) begin
                k = $urandom_range(0, 3);
                m0_read = (k == 1 || k == 3); m0_write = (k >= 2);
                m0_address = rand_addr(); m0_byteenable = 4'($urandom); m0_writedata = $urandom;
            end
            if (!hold1) begin
                k = $urandom_range(0, 3);
                m1_read = (k == 1 || k == 3); m1_write = (k >= 2);
                m1_address = rand_addr(); m1_byteenable = 4'($urandom); m1_writedata = $urandom;
            end
            #1; model_eval();
            if (m0_read | m0_write) begin
                n_total++; if (m0_waitrequest !== (exp_g != 0)) $display("FAIL rnd_wait0 c=%0d got=%b exp=%b", c, m0_waitrequest, exp_g != 0); else n_pass++;
            end
            if (m1_read | m1_write) begin
                n_total++; if (m1_waitrequest !== (exp_g != 1)) $display("FAIL rnd_wait1 c=%0d got=%b exp=%b", c, m1_waitrequest, exp_g != 1); else n_pass++;
            end
            n_total++; if ({ram_chipselect, ram_write} !== {exp_cs, exp_we}) $display("FAIL rnd_ram c=%0d got=%b exp=%b", c, {ram_chipselect, ram_write}, {exp_cs, exp_we}); else n_pass++;
            if (exp_cs) begin
                n_total++; if (ram_address !== exp_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, ram_address, exp_addr); else n_pass++;
            end
            n_total++; if ({m0_readdatavalid, m1_readdatavalid} !== {exp_rdv0, exp_rdv1}) $display("FAIL rnd_rdv c=%0d got=%b exp=%b", c, {m0_readdatavalid, m1_readdatavalid}, {exp_rdv0, exp_rdv1}); else n_pass++;
            n_total++; if (m0_readdata !== exp_rd0) $display("FAIL rnd_rd0 c=%0d got=%h exp=%h", c, m0_readdata, exp_rd0); else n_pass++;
            n_total++; if (m1_readdata !== exp_rd1) $display("FAIL rnd_rd1 c=%0d got=%h exp=%h", c, m1_readdata, exp_rd1); else n_pass++;
            n_total++; if (oor_err !== exp_oor) $display("FAIL rnd_oor c=%0d got=%b exp=%b", c, oor_err, exp_oor); else n_pass++;
            hold0 = (m0_read | m0_write) && (exp_g != 0);
            hold1 = (m1_read | m1_write) && (exp_g != 1);
            model_commit();
        end
        @(negedge clk); set_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_byte_enable();
        test_out_of_range();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_platform_designer_ram_arbiter.md
SPI_PLATFORM_DESIGNER_RAM_ARBITER -- requirements
Module: spi_platform_designer_ram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 14, word-address width; DATA_W, default 32, data width; NUMWORDS, default 10240, populated depth; ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority m0.
REQ-002 SHALL have ports: clk  in  1  single clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: mX_address  in  ADDR_W  word address; mX_byteenable  in  DATA_W/8  byte lanes; mX_read  in  1  read request; mX_write  in  1  write request; mX_writedata  in  DATA_W  write data, for X = 0, 1.
REQ-004 SHALL have ports: mX_waitrequest  out  1  request not accepted this cycle; mX_readdata  out  DATA_W  read data; mX_readdatavalid  out  1  read data valid, for X = 0, 1.
REQ-005 SHALL have ports: ram_address  out  ADDR_W; ram_byteenable  out  DATA_W/8; ram_chipselect  out  1; ram_write  out  1; ram_writedata  out  DATA_W; ram_clken  out  1; ram_readdata  in  DATA_W. The RAM registers its address and returns unregistered data one cycle later.
REQ-006 SHALL have port: oor_err  out  1  sticky flag for an out-of-range access.

Function
REQ-007 A requester SHALL be active when mX_read or mX_write is high. Read and write high together SHALL be treated as a write.
REQ-008 At most one requester SHALL be granted per cycle. The grant SHALL be combinational from the current requests and the last_grant register.
REQ-009 With ARB_MODE=0, when both requesters are active, the requester other than last_grant SHALL win. A single active requester SHALL win.
REQ-010 With ARB_MODE=1, m0 SHALL always win a conflict.
REQ-011 The granted requester SHALL see waitrequest=0. A requester that is active but not granted SHALL see waitrequest=1 and SHALL hold its request stable.
REQ-012 last_grant SHALL update on every grant.
REQ-013 The granted request SHALL drive the RAM in the same cycle: ram_chipselect=1, ram_write=write, and address, byteenable and writedata passed through. With no grant, ram_chipselect=0 and ram_write=0.
REQ-014 ram_clken SHALL be 1 whenever reset_n=1.
REQ-015 A granted read at cycle N SHALL assert the owner's readdatavalid in cycle N+1, with mX_readdata = ram_readdata. The pending-owner register SHALL carry the owner.
REQ-016 Back-to-back reads SHALL be sustained at one per cycle, alternating owners under contention.
REQ-017 readdata for a non-owner SHALL be 0.
REQ-018 An address >= NUMWORDS SHALL be accepted (waitrequest=0) with ram_chipselect=0. A read SHALL return 0 with readdatavalid in N+1. oor_err SHALL set and stay set until reset.
REQ-019 A write by one requester at cycle N followed by a read of the same address at N+1 by either requester SHALL return the new data.
REQ-020 Throughput SHALL be 1 access per cycle; there SHALL be no idle bubbles.

Reset
REQ-021 reset_n low SHALL asynchronously clear: last_grant=1 (so m0 wins the first conflict), the pending read, and oor_err.
REQ-022 While reset_n is low: both waitrequest=1, both readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0.
REQ-023 A read pending when reset asserts SHALL be dropped, with no readdatavalid after reset release.

Structure
REQ-024 A shared package spi_ram_arb_pkg SHALL hold the ADDR_W, DATA_W and NUMWORDS defaults and the owner enum (OWN_M0, OWN_M1, OWN_NONE).
REQ-025 There SHALL be one sub-module, spi_ram_rr_arbiter: 2-way grant logic implementing ARB_MODE, holding the last_grant register.

Verification
REQ-026 Write 0xA5A5A5A5 from m0 to addr 0x10 with byteenable 0xF, then m1 reads 0x10 -> m1_readdatavalid=1 one cycle after grant, data 0xA5A5A5A5.
REQ-027 m0 and m1 both read continuously for 8 cycles, ARB_MODE=0 -> grants alternate m0,m1,...; 4 readdatavalid each; no waitrequest on two consecutive cycles for either.
REQ-028 ARB_MODE=1 with both active for 5 cycles -> m0 granted 5 times; m1_waitrequest=1 throughout.
REQ-029 m0 writes 0x11223344 with byteenable 0x2 over 0xFFFFFFFF at addr 5, then reads addr 5 -> 0xFFFF33FF.
REQ-030 m1 reads addr 10240 -> readdatavalid with data 0; ram_chipselect=0; oor_err=1 until reset_n pulse.
REQ-031 reset_n asserted the cycle after a granted read -> no readdatavalid; after release m0 wins the first conflict.
